// File: rtl/result_reader.sv
// Streams an H x W result map out of storage in row-major order.
// Reads go through a 2-entry skid FIFO so out_ready back-pressure never drops a word.
module result_reader #(
  parameter int W  = 28,
  parameter int H  = 28,
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          rd_en,
  output logic [4:0]    rd_i,
  output logic [4:0]    rd_j,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  localparam int NW = W * H;
  localparam int CW = $clog2(NW + 1);
  localparam logic [4:0]    ROW_LAST = 5'(H - 1);
  localparam logic [4:0]    COL_LAST = 5'(W - 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(NW - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e             state_q;
  logic [4:0]         row_q, col_q;
  logic [1:0][DW-1:0] mem_q;
  logic               rptr_q, wptr_q, inflight_q;
  logic [1:0]         cnt_q;
  logic [CW-1:0]      oidx_q;
  logic               push, pop, last_issue;
  logic [2:0]         credit;

  assign push      = inflight_q;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rptr_q];
  assign out_last  = out_valid && (oidx_q == IDX_LAST);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rd_i      = row_q;
  assign rd_j      = col_q;

  // The word leaving this cycle frees its slot, which keeps a full-rate stream at 1 word/cycle.
  assign credit     = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en      = (state_q == READ) && (credit < 3'd2);
  assign last_issue = rd_en && (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      mem_q      <= '0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      oidx_q     <= '0;
    end else begin
      inflight_q <= rd_en;
      cnt_q      <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        mem_q[wptr_q] <= rd_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
        oidx_q <= oidx_q + CW'(1);
      end
      if (rd_en) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 5'd1;
        end else begin
          col_q <= col_q + 5'd1;
        end
      end
      case (state_q)
        IDLE: if (start) begin
          row_q   <= '0;
          col_q   <= '0;
          oidx_q  <= '0;
          state_q <= READ;
        end
        READ:  if (last_issue) state_q <= DRAIN;
        DRAIN: if (pop && out_last) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && cnt_q == 2'd2));

endmodule
